// File: rtl/alu_writeback_sequencer_if.sv
// alu_writeback_sequencer_if: ALU-result handshake, register-file/flag write side and hazard info.
//   slave  : seen by the sequencer (takes in_*/wb_stall, drives in_ready, rf_*, flag_*, pend_*)
//   master : seen by the ALU/register-file side (the mirror image)
interface alu_writeback_sequencer_if #(
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            in_opcode;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0]     in_result_0;
    logic [DATA_W-1:0]     in_result_1;
    logic [DATA_W-1:0]     in_flags;
    logic                  wb_stall;
    logic                  rf_wr_en;
    logic [REG_ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0]     rf_wr_data;
    logic                  flag_wr_en;
    logic [DATA_W-1:0]     flag_wr_data;
    logic                  pend_valid;
    logic [REG_ADDR_W-1:0] pend_addr;

    modport slave (
        input  in_valid, in_opcode, in_rd, in_result_0, in_result_1, in_flags, wb_stall,
        output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, flag_wr_en, flag_wr_data,
               pend_valid, pend_addr
    );

    modport master (
        output in_valid, in_opcode, in_rd, in_result_0, in_result_1, in_flags, wb_stall,
        input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, flag_wr_en, flag_wr_data,
               pend_valid, pend_addr
    );
endinterface

// File: rtl/alu_writeback_sequencer.sv
// alu_writeback_sequencer: commits ALU results to a single-write-port register file and the flag register.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of alu_writeback_sequencer_if (ALU handshake in, rf/flag writes and
//                pending-destination info out)
module alu_writeback_sequencer #(
    parameter int         REG_ADDR_W = 3,
    parameter int         DATA_W     = 16,
    parameter logic [4:0] OP_MUL     = 5'd4,
    parameter logic [4:0] OP_DIV     = 5'd5,
    parameter logic [4:0] OP_CMP     = 5'd8,
    parameter logic [4:0] OP_SETF    = 5'd9,
    parameter logic [4:0] OP_CLRF    = 5'd10,
    parameter logic [4:0] OP_CPLF    = 5'd11
) (
    input logic                     clk,
    input logic                     reset,
    alu_writeback_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    state_t                state, state_nx;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     res_0, res_1, flags;
    logic                  dual, flag_only;
    logic                  lo, hi, accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd        <= '0;
            res_0     <= '0;
            res_1     <= '0;
            flags     <= '0;
            dual      <= 1'b0;
            flag_only <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rd        <= bus.in_rd;
                res_0     <= bus.in_result_0;
                res_1     <= bus.in_result_1;
                flags     <= bus.in_flags;
                dual      <= bus.in_opcode == OP_MUL || bus.in_opcode == OP_DIV;
                flag_only <= bus.in_opcode == OP_CMP || bus.in_opcode == OP_SETF ||
                             bus.in_opcode == OP_CLRF || bus.in_opcode == OP_CPLF;
            end
        end
    end

    // A new op may enter on the cycle the last beat of the current one completes.
    always_comb begin
        state_nx     = state;
        lo           = state == WR_LO;
        hi           = state == WR_HI;
        bus.in_ready = state == IDLE || (lo && !dual && !bus.wb_stall) || (hi && !bus.wb_stall);
        accept       = bus.in_valid && bus.in_ready;
        if (state == IDLE)
            state_nx = accept ? WR_LO : IDLE;
        else if (!bus.wb_stall)
            state_nx = (lo && dual) ? WR_HI : (accept ? WR_LO : IDLE);
    end

    // Outputs come only from state and captured operands; idle drives all zeros.
    assign bus.rf_wr_en     = (lo && !flag_only) || hi;
    assign bus.rf_wr_addr   = hi ? rd + REG_ADDR_W'(1) : (lo ? rd : '0);
    assign bus.rf_wr_data   = hi ? res_1 : (lo ? res_0 : '0);
    assign bus.flag_wr_en   = lo;
    assign bus.flag_wr_data = lo ? flags : '0;
    assign bus.pend_valid   = bus.rf_wr_en;
    assign bus.pend_addr    = bus.rf_wr_en ? bus.rf_wr_addr : '0;
endmodule
